// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-stage redirect/control inputs and PC/status outputs
interface pc_fetch_unit_if #(parameter int COUNT_WIDTH = 16);
  logic                   stall;
  logic                   halt;
  logic                   resume;
  logic                   branch_taken;
  logic [15:0]            branch_offset;
  logic                   jump;
  logic [25:0]            jump_index;
  logic                   jump_reg;
  logic [31:0]            jr_target;
  logic [31:0]            pc;
  logic [31:0]            pc_plus4;
  logic                   fetch_valid;
  logic                   misaligned;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] fetch_count;
  modport master (
    output stall, halt, resume, branch_taken, branch_offset, jump, jump_index, jump_reg, jr_target,
    input  pc, pc_plus4, fetch_valid, misaligned, halted, fetch_count
  );
  modport slave (
    input  stall, halt, resume, branch_taken, branch_offset, jump, jump_index, jump_reg, jr_target,
    output pc, pc_plus4, fetch_valid, misaligned, halted, fetch_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with branch/jump/jr redirect, stall, halt and misaligned trap
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_unit_if.slave bus
);
  typedef enum logic {RUN, HALT} state_t;
  state_t                 r_state, w_next_state;
  logic [31:0]            r_pc;
  logic                   r_misaligned;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [31:0]            w_pc_plus4, w_br_target, w_jmp_target, w_target;
  logic                   w_go, w_trap, w_load;
  always_comb begin
    w_pc_plus4   = r_pc + 32'd4;
    w_br_target  = w_pc_plus4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    w_jmp_target = {w_pc_plus4[31:28], bus.jump_index, 2'b00};
    w_target     = bus.jump_reg ? bus.jr_target : bus.jump ? w_jmp_target :
                   bus.branch_taken ? w_br_target : w_pc_plus4;
    w_go         = r_state == RUN && !bus.halt && !bus.stall;
    w_trap       = w_go && bus.jump_reg && |bus.jr_target[1:0];
    w_load       = w_go && !w_trap;
  end
  always_comb begin
    w_next_state = r_state;
    if (r_state == RUN && (bus.halt || w_trap))
      w_next_state = HALT;
    else if (r_state == HALT && bus.resume && !bus.halt && !r_misaligned)
      w_next_state = RUN;
  end
  always_ff @(posedge clk)
    r_state <= rst ? RUN : w_next_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_load) r_pc <= w_target;
      if (w_trap) r_misaligned <= 1'b1;
      if (w_load && !(&r_count)) r_count <= r_count + 1'b1;
    end
  end
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.fetch_valid = r_state == RUN;
  assign bus.halted      = r_state == HALT;
  assign bus.misaligned  = r_misaligned;
  assign bus.fetch_count = r_count;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed literal checks plus randomized run against a behavioural PC model
module tb_pc_fetch_unit;
  localparam int CW = 5;
  localparam logic [31:0] CMAX = (32'd1 << CW) - 32'd1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  pc_fetch_unit_if #(.COUNT_WIDTH(CW)) bus ();
  pc_fetch_unit #(.RESET_PC(32'h0), .COUNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  bit          m_ok = 1'b0;
  logic [31:0] m_pc;
  logic        m_halt, m_mis;
  logic [31:0] m_cnt;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask
  always @(posedge clk) begin
    logic [31:0] nxt;
    if (rst) begin
      m_pc = 32'h0; m_halt = 1'b0; m_mis = 1'b0; m_cnt = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (!m_halt) begin
        if (bus.halt) m_halt = 1'b1;
        else if (!bus.stall) begin
          if (bus.jump_reg) nxt = bus.jr_target;
          else if (bus.jump) nxt = {m_pc[31:28] + ((m_pc + 32'd4) >> 28) - (m_pc >> 28) + 4'd0, bus.jump_index, 2'b00};
          else if (bus.branch_taken) nxt = m_pc + 32'd4 + 32'($signed(bus.branch_offset) * 4);
          else nxt = m_pc + 32'd4;
          if (bus.jump_reg && bus.jr_target % 4 != 0) begin
            m_mis = 1'b1; m_halt = 1'b1;
          end else begin
            m_pc = nxt;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
          end
        end
      end else if (bus.resume && !bus.halt && !m_mis) m_halt = 1'b0;
    end
  end
  always @(negedge clk) if (m_ok) begin
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(!m_halt));
    chk("halted", 32'(bus.halted), 32'(m_halt));
    chk("misaligned", 32'(bus.misaligned), 32'(m_mis));
    chk("fetch_count", 32'(bus.fetch_count), m_cnt);
  end
  task automatic clr();
    bus.stall = 0; bus.halt = 0; bus.resume = 0; bus.branch_taken = 0; bus.branch_offset = 0;
    bus.jump = 0; bus.jump_index = 0; bus.jump_reg = 0; bus.jr_target = 0;
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask
  initial begin
    clr();
    step();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_count", 32'(bus.fetch_count), 32'd0);
    chk("rst_valid", 32'(bus.fetch_valid), 32'd1);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_mis", 32'(bus.misaligned), 32'd0);
    rst = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_pc", bus.pc, 32'(4 * i));
    end
    chk("seq_count", 32'(bus.fetch_count), 32'd4);
    rst = 1; step(); rst = 0;
    chk("rerst_pc", bus.pc, 32'h0);
    chk("rerst_count", 32'(bus.fetch_count), 32'd0);
    step(2);
    bus.branch_taken = 1; bus.branch_offset = 16'hFFFE; step();
    chk("br_back", bus.pc, 32'h4);
    bus.branch_offset = 16'h0003; step();
    chk("br_fwd", bus.pc, 32'h14);
    clr(); do_reset(); step(4);
    bus.jump = 1; bus.branch_taken = 1; bus.branch_offset = 16'h0010; bus.jump_index = 26'h40; step();
    chk("jump_over_br", bus.pc, 32'h100);
    bus.jump_reg = 1; bus.jr_target = 32'h200; step();
    chk("jr_over_jump", bus.pc, 32'h200);
    clr(); do_reset();
    bus.jump_reg = 1; bus.jr_target = 32'h20; step(); clr();
    chk("jr_pc", bus.pc, 32'h20);
    bus.stall = 1; bus.branch_taken = 1; bus.branch_offset = 16'h0005; step(3);
    chk("stall_pc", bus.pc, 32'h20);
    chk("stall_count", 32'(bus.fetch_count), 32'd1);
    chk("stall_valid", 32'(bus.fetch_valid), 32'd1);
    clr(); step();
    chk("unstall_pc", bus.pc, 32'h24);
    chk("unstall_count", 32'(bus.fetch_count), 32'd2);
    bus.halt = 1; bus.branch_taken = 1; bus.branch_offset = 16'h0003; step(); clr();
    chk("halt_pc", bus.pc, 32'h24);
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_valid", 32'(bus.fetch_valid), 32'd0);
    bus.resume = 1; bus.halt = 1; step();
    chk("halt_resume_both", 32'(bus.halted), 32'd1);
    bus.halt = 0; step(); bus.resume = 0;
    chk("resume_halted", 32'(bus.halted), 32'd0);
    chk("resume_pc", bus.pc, 32'h24);
    step();
    chk("resume_next_pc", bus.pc, 32'h28);
    bus.jump_reg = 1; bus.jr_target = 32'h302; step(); clr();
    chk("mis_pc", bus.pc, 32'h28);
    chk("mis_flag", 32'(bus.misaligned), 32'd1);
    chk("mis_halted", 32'(bus.halted), 32'd1);
    bus.resume = 1; step(2); bus.resume = 0;
    chk("mis_resume_ignored", 32'(bus.halted), 32'd1);
    do_reset();
    chk("mis_rst_flag", 32'(bus.misaligned), 32'd0);
    chk("mis_rst_halted", 32'(bus.halted), 32'd0);
    bus.jump_reg = 1; bus.jr_target = 32'hFFFF_FFFC; step(); clr();
    chk("top_pc", bus.pc, 32'hFFFF_FFFC);
    chk("top_plus4", bus.pc_plus4, 32'h0);
    step();
    chk("wrap_pc", bus.pc, 32'h0);
    do_reset(); step(35);
    chk("count_sat", 32'(bus.fetch_count), CMAX);
    repeat (3000) begin
      rst = $urandom_range(0, 63) == 0;
      bus.stall = $urandom_range(0, 3) == 0;
      bus.halt = $urandom_range(0, 15) == 0;
      bus.resume = $urandom_range(0, 3) == 0;
      bus.branch_taken = $urandom_range(0, 3) == 0;
      bus.branch_offset = 16'($urandom_range(0, 16'hFFFE));
      bus.jump = $urandom_range(0, 7) == 0;
      bus.jump_index = 26'($urandom);
      bus.jump_reg = $urandom_range(0, 7) == 0;
      bus.jr_target = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      step();
    end
    rst = 0; clr(); step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
